vscale_htif_pcr_initiator: RTL and testbench
============================================

VSCALE_HTIF_PCR_INITIATOR -- requirements
Module: vscale_htif_pcr_initiator

Interface
REQ-001 SHALL have parameter POLL_INTERVAL, default 16: idle cycles between automatic to_host polls (1..65535).
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles waiting in any request or response phase (1..255).
REQ-003 SHALL have parameter TOHOST_ADDR, default 12'h780: CSR address of to_host.
REQ-004 SHALL have parameter FROMHOST_ADDR, default 12'h781: CSR address of from_host (informational; host writes it with a normal command).
REQ-005 SHALL have clk  in  1  clock; all logic is on the rising edge.
REQ-006 SHALL have reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_rw in 1 (1=write), cmd_addr in 12, cmd_data in 64: host command channel.
REQ-008 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_data out 64, rsp_timeout out 1: host response channel, one response per accepted command.
REQ-009 SHALL have htif_pcr_req_valid out 1, htif_pcr_req_ready in 1, htif_pcr_req_rw out 1, htif_pcr_req_addr out 12, htif_pcr_req_data out 64: PCR request to the core.
REQ-010 SHALL have htif_pcr_resp_valid in 1, htif_pcr_resp_ready out 1, htif_pcr_resp_data in 64: PCR response from the core.
REQ-011 SHALL have poll_en in 1 (enables auto-polling), tohost_valid out 1, tohost_ready in 1, tohost_data out 64: to_host message channel.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT, RSP, each tracked with a 1-bit "poll" tag identifying whether the transaction is a poll or a host command.
REQ-013 SHALL hold cmd_ready=1 only in IDLE; on cmd_valid&&cmd_ready, SHALL register rw/addr/data and enter REQ the next cycle, with poll tag=0.
REQ-014 SHALL increment the poll counter in IDLE while poll_en=1, tohost_valid=0, and no command is accepted; when it reaches POLL_INTERVAL-1, SHALL enter REQ with poll tag=1, rw=0, addr=TOHOST_ADDR, data=0, and clear the counter.
REQ-015 SHALL give a host command priority over a poll that would start in the same cycle; the poll counter SHALL then hold its value.
REQ-016 In REQ, SHALL drive htif_pcr_req_valid=1 with fields held stable until htif_pcr_req_ready=1, then enter WAIT.
REQ-017 In WAIT and IDLE, SHALL drive htif_pcr_resp_ready=1; a response seen in IDLE (stray, e.g. after reset) SHALL be discarded.
REQ-018 In WAIT, on htif_pcr_resp_valid, SHALL capture htif_pcr_resp_data; a command goes to RSP with rsp_data=captured and rsp_timeout=0; a poll returns to IDLE.
REQ-019 For a poll response, nonzero data SHALL be loaded into tohost_data with tohost_valid=1; zero data SHALL be dropped.
REQ-020 SHALL hold tohost_valid and tohost_data until tohost_ready=1; no poll SHALL start while tohost_valid=1.
REQ-021 In RSP, SHALL hold rsp_valid=1 until rsp_ready=1, then return to IDLE.
REQ-022 SHALL maintain an 8-bit timeout counter that clears on entry to REQ and WAIT and increments in both states; on reaching TIMEOUT, SHALL drop htif_pcr_req_valid; a command then enters RSP with rsp_data=0 and rsp_timeout=1, and a poll returns to IDLE silently.
REQ-023 Minimum command latency: cmd accepted at cycle N, req_valid at N+1, (responder ready) resp_valid at N+2, rsp_valid at N+3.

Reset
REQ-024 On reset, SHALL set state=IDLE, cmd_ready=1, rsp_valid=0, rsp_timeout=0, rsp_data=0, htif_pcr_req_valid=0, req fields=0, tohost_valid=0, tohost_data=0, and both counters=0.
REQ-025 Reset mid-transaction SHALL abandon the transaction without generating a host response; a late core response SHALL be drained per REQ-017.

Structure
REQ-026 SHALL place the FSM state enum and widths (CSR address 12, PCR data 64, timeout counter 8) in the shared vscale constants header/package.
REQ-027 SHALL have no sub-modules; the single file holds the FSM, two counters, and two output holding registers.

Verification
REQ-028 Write 0x0000_0000_0000_1234 to 12'h781 with a zero-latency responder -> one request (rw=1, addr 0x781), rsp_valid at cycle N+3 with rsp_timeout=0.
REQ-029 poll_en=1, core to_host=0x1 -> read of 0x780 after 16 idle cycles, tohost_valid=1 with data 0x1; with tohost_ready held low, no further polls occur until tohost_ready=1.
REQ-030 cmd_valid asserted in the same cycle the poll would fire -> command issued first, poll issued after the command's response completes.
REQ-031 Responder never asserts htif_pcr_resp_valid -> after 255 WAIT cycles, rsp_valid=1, rsp_timeout=1, rsp_data=0; the FSM then accepts a new command.
REQ-032 Assert reset while in WAIT, then the core returns a response -> response is absorbed in IDLE, and no rsp_valid or tohost_valid is produced.
REQ-033 htif_pcr_req_ready held low for 3 cycles -> request fields stay stable and exactly one request is transferred.

Source files
------------

// File: rtl/vscale_htif_pcr_initiator_pkg.sv
// Shared constants and types for the HTIF PCR initiator.
package vscale_htif_pcr_initiator_pkg;

  localparam int unsigned CSR_ADDR_W    = 12;
  localparam int unsigned PCR_DATA_W    = 64;
  localparam int unsigned TIMEOUT_CNT_W = 8;
  localparam int unsigned POLL_CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } htif_state_e;

  // PCR request payload presented to the core.
  typedef struct packed {
    logic                  rw;
    logic [CSR_ADDR_W-1:0] addr;
    logic [PCR_DATA_W-1:0] data;
  } pcr_req_t;

endpackage

// File: rtl/vscale_htif_pcr_initiator.sv
// HTIF PCR initiator: forwards host CSR commands to the core and
// periodically polls to_host, surfacing nonzero messages to the host.
module vscale_htif_pcr_initiator
  import vscale_htif_pcr_initiator_pkg::*;
#(
  parameter int unsigned           POLL_INTERVAL = 16,
  parameter int unsigned           TIMEOUT       = 255,
  parameter logic [CSR_ADDR_W-1:0] TOHOST_ADDR   = 12'h780,
  parameter logic [CSR_ADDR_W-1:0] FROMHOST_ADDR = 12'h781
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [CSR_ADDR_W-1:0] cmd_addr,
  input  logic [PCR_DATA_W-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [PCR_DATA_W-1:0] rsp_data,
  output logic                  rsp_timeout,
  output logic                  htif_pcr_req_valid,
  input  logic                  htif_pcr_req_ready,
  output logic                  htif_pcr_req_rw,
  output logic [CSR_ADDR_W-1:0] htif_pcr_req_addr,
  output logic [PCR_DATA_W-1:0] htif_pcr_req_data,
  input  logic                  htif_pcr_resp_valid,
  output logic                  htif_pcr_resp_ready,
  input  logic [PCR_DATA_W-1:0] htif_pcr_resp_data,
  input  logic                  poll_en,
  output logic                  tohost_valid,
  input  logic                  tohost_ready,
  output logic [PCR_DATA_W-1:0] tohost_data
);

  localparam logic [POLL_CNT_W-1:0]    POLL_LAST = POLL_CNT_W'(POLL_INTERVAL - 1);
  localparam logic [TIMEOUT_CNT_W-1:0] TO_LAST   = TIMEOUT_CNT_W'(TIMEOUT - 1);

  // Elaboration-time sanity checks on the parameter set.
  if (POLL_INTERVAL < 1 || POLL_INTERVAL > 65535) begin : g_bad_poll
    $error("POLL_INTERVAL out of range");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT out of range");
  end
  if (TOHOST_ADDR == FROMHOST_ADDR) begin : g_addr_clash
    $error("TOHOST_ADDR and FROMHOST_ADDR must differ");
  end

  htif_state_e               state_q, state_d;
  logic                      poll_q, poll_d;
  pcr_req_t                  req_q, req_d;
  logic [POLL_CNT_W-1:0]     poll_cnt_q, poll_cnt_d;
  logic [TIMEOUT_CNT_W-1:0]  to_cnt_q, to_cnt_d;
  logic [PCR_DATA_W-1:0]     rsp_data_q, rsp_data_d;
  logic                      rsp_timeout_q, rsp_timeout_d;
  logic                      tohost_valid_q, tohost_valid_d;
  logic [PCR_DATA_W-1:0]     tohost_data_q, tohost_data_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      req_valid_q, req_valid_d;
  logic                      resp_ready_q, resp_ready_d;
  logic                      to_expired;

  // State, counters and output holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      poll_q         <= 1'b0;
      req_q          <= '0;
      poll_cnt_q     <= '0;
      to_cnt_q       <= '0;
      rsp_data_q     <= '0;
      rsp_timeout_q  <= 1'b0;
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= '0;
      cmd_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      req_valid_q    <= 1'b0;
      resp_ready_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      poll_q         <= poll_d;
      req_q          <= req_d;
      poll_cnt_q     <= poll_cnt_d;
      to_cnt_q       <= to_cnt_d;
      rsp_data_q     <= rsp_data_d;
      rsp_timeout_q  <= rsp_timeout_d;
      tohost_valid_q <= tohost_valid_d;
      tohost_data_q  <= tohost_data_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      req_valid_q    <= req_valid_d;
      resp_ready_q   <= resp_ready_d;
    end
  end

  // Next-state, counter and holding-register update.
  always_comb begin
    state_d        = state_q;
    poll_d         = poll_q;
    req_d          = req_q;
    poll_cnt_d     = poll_cnt_q;
    to_cnt_d       = to_cnt_q;
    rsp_data_d     = rsp_data_q;
    rsp_timeout_d  = rsp_timeout_q;
    tohost_valid_d = tohost_valid_q;
    tohost_data_d  = tohost_data_q;
    to_expired     = (to_cnt_q == TO_LAST);

    if (tohost_valid_q && tohost_ready) begin
      tohost_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        // Host command wins; the poll counter simply holds.
        if (cmd_valid && cmd_ready_q) begin
          state_d   = ST_REQ;
          poll_d    = 1'b0;
          req_d.rw   = cmd_rw;
          req_d.addr = cmd_addr;
          req_d.data = cmd_data;
          to_cnt_d  = '0;
        end else if (poll_en && !tohost_valid_q) begin
          if (poll_cnt_q == POLL_LAST) begin
            state_d    = ST_REQ;
            poll_d     = 1'b1;
            req_d.rw   = 1'b0;
            req_d.addr = TOHOST_ADDR;
            req_d.data = '0;
            poll_cnt_d = '0;
            to_cnt_d   = '0;
          end else begin
            poll_cnt_d = poll_cnt_q + POLL_CNT_W'(1);
          end
        end
      end
      ST_REQ: begin
        if (htif_pcr_req_ready) begin
          state_d  = ST_WAIT;
          to_cnt_d = '0;
        end else if (to_expired) begin
          state_d = poll_q ? ST_IDLE : ST_RSP;
          if (!poll_q) begin
            rsp_data_d    = '0;
            rsp_timeout_d = 1'b1;
          end
        end else begin
          to_cnt_d = to_cnt_q + TIMEOUT_CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (htif_pcr_resp_valid) begin
          if (poll_q) begin
            state_d = ST_IDLE;
            // Empty to_host reads carry no message.
            if (htif_pcr_resp_data != '0) begin
              tohost_valid_d = 1'b1;
              tohost_data_d  = htif_pcr_resp_data;
            end
          end else begin
            state_d       = ST_RSP;
            rsp_data_d    = htif_pcr_resp_data;
            rsp_timeout_d = 1'b0;
          end
        end else if (to_expired) begin
          state_d = poll_q ? ST_IDLE : ST_RSP;
          if (!poll_q) begin
            rsp_data_d    = '0;
            rsp_timeout_d = 1'b1;
          end
        end else begin
          to_cnt_d = to_cnt_q + TIMEOUT_CNT_W'(1);
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d  = (state_d == ST_IDLE);
    req_valid_d  = (state_d == ST_REQ);
    rsp_valid_d  = (state_d == ST_RSP);
    resp_ready_d = (state_d == ST_WAIT) || (state_d == ST_IDLE);
  end

  assign cmd_ready           = cmd_ready_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_data            = rsp_data_q;
  assign rsp_timeout         = rsp_timeout_q;
  assign htif_pcr_req_valid  = req_valid_q;
  assign htif_pcr_req_rw     = req_q.rw;
  assign htif_pcr_req_addr   = req_q.addr;
  assign htif_pcr_req_data   = req_q.data;
  assign htif_pcr_resp_ready = resp_ready_q;
  assign tohost_valid        = tohost_valid_q;
  assign tohost_data         = tohost_data_q;

endmodule

// File: tb/tb_vscale_htif_pcr_initiator.sv
// Scoreboard bench for the HTIF PCR initiator with a behavioural core model.
module tb_vscale_htif_pcr_initiator;
  import vscale_htif_pcr_initiator_pkg::*;

  localparam int unsigned TIMEOUT = 255;
  localparam logic [11:0] TOHOST  = 12'h780;

  typedef struct packed {
    logic [63:0] data;
    logic        to;
  } rsp_exp_t;

  logic        clk;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [11:0] cmd_addr;
  logic [63:0] cmd_data;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [63:0] rsp_data;
  logic        htif_pcr_req_valid, htif_pcr_req_ready, htif_pcr_req_rw;
  logic [11:0] htif_pcr_req_addr;
  logic [63:0] htif_pcr_req_data;
  logic        htif_pcr_resp_valid, htif_pcr_resp_ready;
  logic [63:0] htif_pcr_resp_data;
  logic        poll_en, tohost_valid, tohost_ready;
  logic [63:0] tohost_data;

  vscale_htif_pcr_initiator dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout),
    .htif_pcr_req_valid(htif_pcr_req_valid), .htif_pcr_req_ready(htif_pcr_req_ready),
    .htif_pcr_req_rw(htif_pcr_req_rw), .htif_pcr_req_addr(htif_pcr_req_addr),
    .htif_pcr_req_data(htif_pcr_req_data),
    .htif_pcr_resp_valid(htif_pcr_resp_valid), .htif_pcr_resp_ready(htif_pcr_resp_ready),
    .htif_pcr_resp_data(htif_pcr_resp_data),
    .poll_en(poll_en), .tohost_valid(tohost_valid), .tohost_ready(tohost_ready),
    .tohost_data(tohost_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference CSR space (host view) and the core's CSR space.
  bit [63:0] ref_mem  [0:4095];
  bit [63:0] core_mem [0:4095];

  pcr_req_t    exp_req [$];
  rsp_exp_t    exp_rsp [$];
  logic [63:0] exp_toh [$];

  int ready_delay = 0;
  int resp_delay  = 0;
  bit no_resp     = 0;
  bit rand_rsp    = 0;
  int req_count   = 0;
  int resp_hs_count = 0;

  int cyc = 0, acc_cyc = 0, last_req_hs_cyc = 0, rsp_rise_cyc = 0, rsp_lat = 0;
  int rsp_rises = 0, toh_rises = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    fails++;
    $display("FAIL %s: event observed/missing contrary to expectation", name);
  endtask

  // Core responder: random ready/response latency, read-clear on to_host.
  initial begin : responder
    bit          busy;
    int          rcnt, dcnt;
    logic [63:0] rdata;
    logic        pv, pr, qv, qr;
    pcr_req_t    pf;
    busy = 0; rcnt = 0; dcnt = 0; rdata = '0;
    pv = 0; pr = 0; qv = 0; qr = 0; pf = '0;
    htif_pcr_req_ready = 1'b0;
    htif_pcr_resp_valid = 1'b0;
    htif_pcr_resp_data = '0;
    forever begin
      @(negedge clk);
      if (qv && qr) begin
        htif_pcr_resp_valid = 1'b0;
        busy = 0;
        resp_hs_count++;
      end
      if (pv && pr) begin
        req_count++;
        htif_pcr_req_ready = 1'b0;
        rcnt = 0;
        rdata = core_mem[pf.addr];
        if (pf.rw) core_mem[pf.addr] = pf.data;
        else if (pf.addr == TOHOST) core_mem[pf.addr] = '0;
        if (!no_resp) begin
          busy = 1;
          dcnt = 0;
        end
      end
      if (busy && !htif_pcr_resp_valid) begin
        if (dcnt >= resp_delay) begin
          htif_pcr_resp_valid = 1'b1;
          htif_pcr_resp_data  = rdata;
        end else begin
          dcnt++;
        end
      end
      if (!htif_pcr_req_valid) begin
        htif_pcr_req_ready = 1'b0;
        rcnt = 0;
      end else if (!htif_pcr_req_ready) begin
        if (rcnt >= ready_delay) htif_pcr_req_ready = 1'b1;
        else rcnt++;
      end
      pv = htif_pcr_req_valid;
      pr = htif_pcr_req_ready;
      pf = '{rw: htif_pcr_req_rw, addr: htif_pcr_req_addr, data: htif_pcr_req_data};
      qv = htif_pcr_resp_valid;
      qr = htif_pcr_resp_ready;
    end
  end

  // Host response back-pressure.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(negedge clk);
      rsp_ready = rand_rsp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: samples between edges, pops the scoreboard on each handshake.
  initial begin : monitor
    bit        stall_prev, rsp_prev, toh_prev;
    logic [76:0] stall_f;
    pcr_req_t  er;
    rsp_exp_t  es;
    logic [63:0] et;
    stall_prev = 0; rsp_prev = 0; toh_prev = 0; stall_f = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (reset) begin
        stall_prev = 0; rsp_prev = 0; toh_prev = 0;
        continue;
      end
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (stall_prev) begin
        check("req_hold_valid", 128'(htif_pcr_req_valid), 128'(1));
        check("req_hold_fields", 128'({htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data}), 128'(stall_f));
      end
      stall_prev = htif_pcr_req_valid && !htif_pcr_req_ready;
      stall_f = {htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data};
      if (htif_pcr_req_valid && htif_pcr_req_ready) begin
        last_req_hs_cyc = cyc;
        if (exp_req.size() == 0) fail_evt("req_unexpected");
        else begin
          er = exp_req.pop_front();
          check("req_rw", 128'(htif_pcr_req_rw), 128'(er.rw));
          check("req_addr", 128'(htif_pcr_req_addr), 128'(er.addr));
          check("req_data", 128'(htif_pcr_req_data), 128'(er.data));
        end
      end
      if (rsp_valid && !rsp_prev) begin
        rsp_rise_cyc = cyc;
        rsp_lat = cyc - acc_cyc;
        rsp_rises++;
      end
      rsp_prev = rsp_valid && !rsp_ready;
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) fail_evt("rsp_unexpected");
        else begin
          es = exp_rsp.pop_front();
          check("rsp_data", 128'(rsp_data), 128'(es.data));
          check("rsp_timeout", 128'(rsp_timeout), 128'(es.to));
        end
      end
      if (tohost_valid && !toh_prev) begin
        toh_rises++;
        if (exp_toh.size() == 0) fail_evt("tohost_unexpected");
      end
      toh_prev = tohost_valid && !tohost_ready;
      if (tohost_valid && tohost_ready && exp_toh.size() != 0) begin
        et = exp_toh.pop_front();
        check("tohost_data", 128'(tohost_data), 128'(et));
      end
    end
  end

  // mode 0: normal response expected; 1: timeout response; 2: no response.
  task automatic issue(input logic rw, input logic [11:0] addr, input logic [63:0] data, input int mode);
    bit ok = 0;
    logic [63:0] old;
    cmd_rw = rw; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    for (int i = 0; i < 600 && !ok; i++) begin
      #2;
      if (cmd_ready) ok = 1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!ok) fail_evt("cmd_accept");
    else begin
      exp_req.push_back('{rw: rw, addr: addr, data: data});
      old = ref_mem[addr];
      if (rw) ref_mem[addr] = data;
      if (mode == 0) exp_rsp.push_back('{data: old, to: 1'b0});
      else if (mode == 1) exp_rsp.push_back('{data: 64'h0, to: 1'b1});
    end
  endtask

  task automatic wait_rsp_drain(input string name);
    int n = 0;
    while (exp_rsp.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(exp_rsp.size()), 128'(0));
  endtask

  task automatic wait_req(input int target, input string name);
    int n = 0;
    while (req_count < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(req_count >= target), 128'(1));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int rc0, hs0, r0, t0, n;
    reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_data = '0;
    poll_en = 1'b0; tohost_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_rsp_timeout", 128'(rsp_timeout), 128'(0));
    check("rst_rsp_data", 128'(rsp_data), 128'(0));
    check("rst_req_valid", 128'(htif_pcr_req_valid), 128'(0));
    check("rst_req_fields", 128'({htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data}), 128'(0));
    check("rst_resp_ready", 128'(htif_pcr_resp_ready), 128'(1));
    check("rst_tohost_valid", 128'(tohost_valid), 128'(0));
    check("rst_tohost_data", 128'(tohost_data), 128'(0));
    @(negedge clk);
    reset = 1'b0;

    // Write to from_host with an immediate responder; check latency, then read back.
    issue(1'b1, 12'h781, 64'h0000_0000_0000_1234, 0);
    wait_rsp_drain("wr_drain");
    check("cmd_to_rsp_latency", 128'(rsp_lat), 128'(3));
    issue(1'b0, 12'h781, 64'h0, 0);
    wait_rsp_drain("rd_drain");

    // Request held off by the core for 3 cycles: one transfer, stable fields.
    ready_delay = 3;
    rc0 = req_count;
    issue(1'b1, 12'h123, 64'hDEAD_BEEF_0BAD_F00D, 0);
    wait_rsp_drain("stall_drain");
    check("one_req_transfer", 128'(req_count - rc0), 128'(1));

    // Randomized command traffic with random core and host back-pressure.
    rand_rsp = 1;
    for (int i = 0; i < 40; i++) begin
      ready_delay = $urandom_range(0, 3);
      resp_delay  = $urandom_range(0, 4);
      issue(1'($urandom_range(0, 1)), 12'h100 + 12'($urandom_range(0, 7)),
            {$urandom, $urandom}, 0);
    end
    wait_rsp_drain("random_drain");
    rand_rsp = 0; ready_delay = 0; resp_delay = 0;

    // Core never responds: timeout response, then normal service resumes.
    no_resp = 1;
    issue(1'b0, 12'h100, 64'h0, 1);
    wait_rsp_drain("timeout_drain");
    // Handshake sample to rsp_valid sample spans TIMEOUT wait cycles plus one.
    check("timeout_wait_cycles", 128'(rsp_rise_cyc - last_req_hs_cyc), 128'(TIMEOUT + 1));
    no_resp = 0;
    issue(1'b0, 12'h781, 64'h0, 0);
    wait_rsp_drain("post_timeout_drain");

    // Reset while waiting on the core; the late response must be absorbed silently.
    resp_delay = 12;
    rc0 = req_count;
    hs0 = resp_hs_count;
    issue(1'b0, 12'h101, 64'h0, 2);
    wait_req(rc0 + 1, "rst_wait_req_sent");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    r0 = rsp_rises;
    t0 = toh_rises;
    n = 0;
    while (resp_hs_count == hs0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("late_resp_drained", 128'(resp_hs_count - hs0), 128'(1));
    repeat (20) @(negedge clk);
    check("no_rsp_after_reset", 128'(rsp_rises - r0), 128'(0));
    check("no_tohost_after_reset", 128'(toh_rises - t0), 128'(0));
    resp_delay = 0;

    // Poll: to_host=1 is read after 16 idle cycles and held until accepted.
    core_mem[TOHOST] = 64'h1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    poll_en = 1'b1;
    tohost_ready = 1'b0;
    exp_req.push_back('{rw: 1'b0, addr: TOHOST, data: 64'h0});
    exp_toh.push_back(64'h1);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      #1;
      if (htif_pcr_req_valid) begin
        n = i;
        break;
      end
    end
    check("poll_idle_cycles", 128'(n), 128'(16));
    n = 0;
    while (!tohost_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("tohost_valid_set", 128'(tohost_valid), 128'(1));
    check("tohost_value", 128'(tohost_data), 128'(64'h1));
    rc0 = req_count;
    repeat (100) @(negedge clk);
    check("no_poll_while_tohost", 128'(req_count - rc0), 128'(0));
    check("tohost_still_held", 128'(tohost_valid), 128'(1));
    exp_req.push_back('{rw: 1'b0, addr: TOHOST, data: 64'h0});
    tohost_ready = 1'b1;
    wait_req(rc0 + 1, "poll_resumes");
    poll_en = 1'b0;
    repeat (5) @(negedge clk);

    // Command arrives on the cycle the poll would fire: command first, poll after.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    poll_en = 1'b1;
    rc0 = req_count;
    repeat (15) @(negedge clk);
    issue(1'b1, 12'h102, 64'h0123_4567_89AB_CDEF, 0);
    exp_req.push_back('{rw: 1'b0, addr: TOHOST, data: 64'h0});
    wait_rsp_drain("prio_drain");
    check("poll_deferred", 128'(req_count - rc0), 128'(1));
    wait_req(rc0 + 2, "poll_after_cmd");
    poll_en = 1'b0;
    repeat (10) @(negedge clk);

    check("exp_req_empty", 128'(exp_req.size()), 128'(0));
    check("exp_rsp_empty", 128'(exp_rsp.size()), 128'(0));
    check("exp_toh_empty", 128'(exp_toh.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
